// File: rtl/hilo_if.sv
// HI/LO unit bus: EX-stage instruction inputs, divider handshake and HI/LO results.
//   op_valid, funct, rs_data, rt_data : EX-stage instruction and operands
//   div_dataA, div_dataB, div_signal  : latched operands and start code to the divider
//   div_result                        : divider output {remainder, quotient}
//   stall, hilo_out, hi, lo           : pipeline freeze, MFHI/MFLO data, HI/LO registers
// The slave modport is the HI/LO unit; the master modport is its environment.
interface hilo_if;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] div_dataA;
  logic [31:0] div_dataB;
  logic [5:0]  div_signal;
  logic [63:0] div_result;
  logic        stall;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, funct, rs_data, rt_data, div_result,
    input  div_dataA, div_dataB, div_signal, stall, hilo_out, hi, lo
  );

  modport slave (
    input  op_valid, funct, rs_data, rt_data, div_result,
    output div_dataA, div_dataB, div_signal, stall, hilo_out, hi, lo
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file and sequencer for a fixed-latency multicycle unsigned divider.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : hilo_if slave (instruction in, divider handshake, stall, HI/LO read data)
// A DIVU latches its operands, issues a one-cycle start code, waits the divider latency
// and captures {remainder, quotient} into {HI, LO}. Only HI/LO instructions stall while busy.
module hilo_unit #(
  parameter int unsigned DivLatency = 33,
  parameter logic [5:0]  FunctDivu  = 6'd27,
  parameter logic [5:0]  FunctMfhi  = 6'd16,
  parameter logic [5:0]  FunctMthi  = 6'd17,
  parameter logic [5:0]  FunctMflo  = 6'd18,
  parameter logic [5:0]  FunctMtlo  = 6'd19
) (
  input logic   clk,
  input logic   reset,
  hilo_if.slave bus
);

  localparam logic [5:0] LastCnt = 6'(DivLatency - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic is_divu, is_mfhi, is_mthi, is_mflo, is_mtlo, hilo_op;

  always_comb begin
    is_divu = bus.funct == FunctDivu;
    is_mfhi = bus.funct == FunctMfhi;
    is_mthi = bus.funct == FunctMthi;
    is_mflo = bus.funct == FunctMflo;
    is_mtlo = bus.funct == FunctMtlo;
    hilo_op = bus.op_valid & (is_divu | is_mfhi | is_mthi | is_mflo | is_mtlo);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (hilo_op) begin
          if (is_divu) begin
            a_d     = bus.rs_data;
            b_d     = bus.rt_data;
            state_d = StIssue;
          end
          if (is_mthi) hi_d = bus.rs_data;
          if (is_mtlo) lo_d = bus.rs_data;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastCnt) state_d = StCapture;
      end
      StCapture: begin
        hi_d    = bus.div_result[63:32];
        lo_d    = bus.div_result[31:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Start code is decoded from the ISSUE state, so it can never last more than one cycle.
  always_comb begin
    bus.div_signal = (state_q == StIssue) ? FunctDivu : 6'd0;
    bus.stall      = (state_q != StIdle) & hilo_op;
    bus.hilo_out   = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);
    bus.div_dataA  = a_q;
    bus.div_dataB  = b_q;
    bus.hi         = hi_q;
    bus.lo         = lo_q;
  end

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
  localparam logic [63:0] Poison = 64'hBADBAD00_0BADBAD0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_if bus ();

  hilo_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total;
  int bad;

  // Reference model: remaining busy cycles after a DIVU accept, plus architectural state.
  int          busy;
  logic [31:0] m_hi, m_lo, m_a, m_b;

  // Divider model: result is poisoned until DivLatency cycles after it samples the start code.
  int          dv_cnt;
  logic [63:0] dv_res;

  logic        last_stall;
  logic [31:0] last_hilo;
  logic [5:0]  last_dsig;

  typedef struct {
    logic        v;
    logic [5:0]  f;
    logic [31:0] rs;
    logic        exp_stall;
    logic [31:0] exp_out;
  } vec_t;

  function automatic logic [63:0] div_ref(logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [5:0] f, logic [31:0] rs, logic [31:0] rt);
    bus.op_valid = v;
    bus.funct    = f;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
  endtask

  // Check outputs mid-cycle against the model, then clock once and advance both models.
  task automatic step();
    logic        r, v, hop;
    logic [5:0]  f, dsig;
    logic [31:0] rs, rt, da, db, exp_out;
    #3;
    r   = reset;
    v   = bus.op_valid;
    f   = bus.funct;
    rs  = bus.rs_data;
    rt  = bus.rt_data;
    hop = v && (f inside {[6'd16:6'd19], 6'd27});
    exp_out = (f == 6'd16) ? m_hi : ((f == 6'd18) ? m_lo : 32'd0);
    chk("stall", bus.stall, (busy > 0) && hop);
    chk("div_signal", bus.div_signal, (busy == 35) ? 6'd27 : 6'd0);
    chk("hilo_out", bus.hilo_out, exp_out);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("div_dataA", bus.div_dataA, m_a);
    chk("div_dataB", bus.div_dataB, m_b);
    last_stall = bus.stall;
    last_hilo  = bus.hilo_out;
    last_dsig  = bus.div_signal;
    dsig = bus.div_signal;
    da   = bus.div_dataA;
    db   = bus.div_dataB;
    @(posedge clk);
    if (r) begin
      busy = 0;
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) {m_hi, m_lo} = div_ref(m_a, m_b);
    end else if (v) begin
      case (f)
        6'd27: begin m_a = rs; m_b = rt; busy = 35; end
        6'd17: m_hi = rs;
        6'd19: m_lo = rs;
        default: ;
      endcase
    end
    if (dsig == 6'd27) begin
      dv_cnt = 33;
      dv_res = div_ref(da, db);
    end else if (dv_cnt > 0) begin
      dv_cnt--;
    end
    #1;
    bus.div_result = (dv_cnt == 0) ? dv_res : Poison;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[5];
    int          n, nsig, sig_at, nst;
    logic [5:0]  rf;
    logic [5:0]  fsel[7];
    total = 0; bad = 0; busy = 0;
    m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
    dv_cnt = 0; dv_res = Poison;
    bus.div_result = Poison;
    reset = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    step();  // reset state: everything zero
    reset = 1'b0;

    // DIVU 100/7: one-cycle start code, capture 35 edges later, no stalls.
    drive(1'b1, 6'd27, 32'd100, 32'd7);
    step();
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    nsig = 0; sig_at = -1; nst = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (last_dsig != 6'd0) begin nsig++; if (sig_at < 0) sig_at = i; end
      if (last_stall) nst++;
      if (i == 33) chk("t1_hi_early", bus.hi, 32'd0);
    end
    chk("t1_sig_count", nsig, 1);
    chk("t1_sig_pos", sig_at, 0);
    chk("t1_stalls", nst, 0);
    chk("t1_hi", bus.hi, 32'd2);
    chk("t1_lo", bus.lo, 32'd14);

    // DIVU 0xFFFFFFFF/0x10 with MFLO waiting behind it.
    drive(1'b1, 6'd27, 32'hFFFF_FFFF, 32'h10);
    step();
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    step();
    drive(1'b1, 6'd18, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_stall) n++;
      else break;
    end
    chk("t2_stall_cycles", n, 34);
    chk("t2_mflo", last_hilo, 32'h0FFF_FFFF);
    chk("t2_hi", bus.hi, 32'hF);
    drive(1'b0, 6'd0, 32'd0, 32'd0);

    // Moves in IDLE, table-driven.
    tbl[0] = '{1'b1, 6'd17, 32'hDEAD_BEEF, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 6'd19, 32'h1234_5678, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 6'd16, 32'd0,         1'b0, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 6'd18, 32'd0,         1'b0, 32'h1234_5678};
    tbl[4] = '{1'b1, 6'd32, 32'd5,         1'b0, 32'd0};
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].rs, 32'd0);
      step();
      chk("t3_stall", last_stall, tbl[i].exp_stall);
      chk("t3_hilo_out", last_hilo, tbl[i].exp_out);
    end

    // DIVU 50/5 with ADDs flowing during the divide.
    drive(1'b1, 6'd27, 32'd50, 32'd5);
    step();
    nst = 0;
    for (int i = 0; i < 35; i++) begin
      drive(1'b1, 6'd32, $urandom, $urandom);
      step();
      if (last_stall) nst++;
    end
    chk("t4_add_stalls", nst, 0);
    chk("t4_lo", bus.lo, 32'd10);
    chk("t4_hi", bus.hi, 32'd0);

    // Reset mid-divide abandons it.
    drive(1'b1, 6'd27, 32'd100, 32'd7);
    step();
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 6'd16, 32'd0, 32'd0);
    step();
    chk("t5_idle_no_stall", last_stall, 1'b0);
    chk("t5_dsig", last_dsig, 6'd0);
    chk("t5_hi", bus.hi, 32'd0);
    chk("t5_lo", bus.lo, 32'd0);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (40) step();
    chk("t5_hi_late", bus.hi, 32'd0);
    chk("t5_lo_late", bus.lo, 32'd0);

    // Back-to-back DIVU.
    drive(1'b1, 6'd27, 32'd9, 32'd2);
    step();
    drive(1'b1, 6'd27, 32'd20, 32'd6);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_stall) n++;
      else break;
    end
    chk("t6_stall_cycles", n, 35);
    chk("t6_hi1", bus.hi, 32'd1);
    chk("t6_lo1", bus.lo, 32'd4);
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (35) step();
    chk("t6_hi2", bus.hi, 32'd2);
    chk("t6_lo2", bus.lo, 32'd3);

    // Randomized traffic against the model; stalled instructions are held.
    fsel = '{6'd27, 6'd16, 6'd17, 6'd18, 6'd19, 6'd32, 6'd0};
    for (int i = 0; i < 1500; i++) begin
      if (!last_stall) begin
        rf = fsel[$urandom_range(0, 6)];
        if (rf == 6'd0) rf = 6'($urandom);
        drive(($urandom_range(0, 3) != 0), rf, $urandom,
              ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sequencer and HI/LO register file placed directly in front of the multicycle unsigned divider, in the EX stage.
- Accepts DIVU and HI/LO move instructions and latches the divide operands.
- Issues a single-cycle start code to the divider, counts its fixed latency, then captures the 64-bit {remainder, quotient} result into HI/LO.
- Stalls only those later instructions that touch HI/LO while a divide is in flight.

Parameters:
DIV_LATENCY, 33, cycles from the divider sampling the start code to its result output being stable
FUNCT_DIVU, 6'd27, funct code that starts a divide
FUNCT_MFHI, 6'd16, move from HI
FUNCT_MTHI, 6'd17, move to HI
FUNCT_MFLO, 6'd18, move from LO
FUNCT_MTLO, 6'd19, move to LO

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op_valid  input  1  EX-stage instruction is valid
funct  input  6  EX-stage funct field
rs_data  input  32  dividend / MTHI / MTLO source
rt_data  input  32  divisor
div_dataA  output  32  latched dividend to the divider
div_dataB  output  32  latched divisor to the divider
div_signal  output  6  start code to the divider; FUNCT_DIVU for exactly one cycle per divide, otherwise 0
div_result  input  64  divider output: [63:32] remainder, [31:0] quotient
stall  output  1  freeze IF/ID/EX (combinational)
hilo_out  output  32  MFHI/MFLO read data (combinational)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cnt=0, hi=0, lo=0, div_dataA=0, div_dataB=0, div_signal=0.
  - Reset wins over every other event on the same edge.
  - Reset during a divide abandons it: HI/LO stay 0 and div_result is never captured.
- hilo_op = op_valid & funct in {DIVU, MFHI, MTHI, MFLO, MTLO}. Any other funct is ignored and never stalled.
- States:
  - IDLE:
    - hilo_op & DIVU: latch rs_data→div_dataA and rt_data→div_dataB, go to ISSUE. stall=0.
    - MTHI: hi<=rs_data. MTLO: lo<=rs_data. Both written at the edge.
  - ISSUE (1 cycle): div_signal=FUNCT_DIVU, cnt<=0, go to WAIT.
  - WAIT: div_signal=0, cnt<=cnt+1. When cnt==DIV_LATENCY-1, go to CAPTURE.
  - CAPTURE (1 cycle): hi<=div_result[63:32], lo<=div_result[31:0], go to IDLE.
- Timing: DIVU accepted at edge A. div_signal is high during cycle A..A+1. HI/LO are updated at edge A+35. The unit is back in IDLE from A+35, giving 35 busy cycles (ISSUE, 33 WAIT, CAPTURE).
- stall = (state!=IDLE) & hilo_op.
  - Non-HI/LO instructions proceed while the divide runs.
  - A stalled instruction is re-presented every cycle and is accepted in the first IDLE cycle.
  - A stalled MFHI/MFLO reads the newly captured value.
- hilo_out = hi when funct==MFHI, lo when funct==MFLO, else 0.
  - Reflects the registers combinationally.
  - Meaningful only when stall=0.
- div_dataA/div_dataB hold their values from acceptance through CAPTURE and change only on the next DIVU accept.
- Divide by zero: no special case or exception. The divider runs normally and HI/LO take div_result unchanged; latency is unchanged.
- Back-to-back DIVU: the second one stalls until IDLE, then starts a fresh ISSUE. div_signal never stays high for 2 consecutive cycles.
- cnt is 6 bits and never wraps: DIV_LATENCY≤63.

Test Plan:
- Reset, then DIVU with rs=100, rt=7 at edge A: div_signal=27 only in cycle A..A+1; at A+35, hi=2, lo=14; stall=0 throughout with no following HI/LO op.
- DIVU 0xFFFFFFFF/0x10, then MFLO presented on the next cycle: stall=1 for 34 cycles; in the first IDLE cycle stall=0 and hilo_out=0x0FFFFFFF; hi=0xF.
- MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678, then MFHI, then MFLO, all in IDLE: no stall; hilo_out=0xDEADBEEF, then 0x12345678.
- DIVU 50/5, with ADD-funct ops presented during WAIT: stall=0 for every ADD; lo=10, hi=0.
- DIVU 100/7, reset asserted 10 cycles after accept: next cycle state=IDLE, hi=lo=0, div_signal=0; 40 more cycles with no op leave hi=lo=0.
- Two consecutive DIVU (9/2, then 20/6): second held with stall=1 until IDLE; first gives hi=1, lo=4; second gives hi=2, lo=3, 35 cycles after its accept.
